alu_issue_ctrl: RTL



---
 rtl/alu_issue_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Instruction decode/issue sequencer sitting between instruction fetch and the
// combinational ALU. Accepts one 32-bit instruction word per valid/ready
// handshake, reads operands from an internal register file, presents the
// decoded fields to the ALU, evaluates the condition field against the
// architectural NZCV flags, and writes back the ALU result and flags.
//
// Instruction word:
//   [31:28] cond   [27:24] opc   [23] s   [22] imm
//   [21:19] rd     [18:16] rn
//   imm=0: [15:13] rm, [12:8] n     (i = 0)
//   imm=1: [15:0]  i                (n = 0, alu_b = 0)
//
// Sequencing: IDLE -> ISSUE -> WB -> IDLE, one instruction every 3 cycles.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   instr_valid/ready/instr instruction handshake and word
//   alu_op/a/b/s/n/i       registered ALU controls and operands
//   alu_result, alu_flags  combinational ALU response {N,Z,C,V}
//   flags                  architectural flag register {N,Z,C,V}
//   done, done_skipped     one-cycle writeback pulse; skipped = cond failed
//   dbg_addr, dbg_data     combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_s,
    output logic [4:0]        alu_n,
    output logic [15:0]       alu_i,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              done,
    output logic              done_skipped,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NUM_REGS = 2 ** RA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WB
    } state_t;

    state_t state;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Fields of the instruction currently in flight.
    logic [3:0]        cond_q;
    logic              s_q;
    logic [RA_W-1:0]   rd_q;

    // ALU response captured at the end of ISSUE, committed in WB.
    logic [DATA_W-1:0] result_q;
    logic [3:0]        alu_flags_q;
    logic              pass_q;

    // Decode of the incoming word (only consumed on acceptance).
    logic [RA_W-1:0]   dec_rd;
    logic [RA_W-1:0]   dec_rn;
    logic [RA_W-1:0]   dec_rm;
    logic              dec_imm;
    logic              cond_pass;

    assign dec_rd  = instr[19 +: RA_W];
    assign dec_rn  = instr[16 +: RA_W];
    assign dec_rm  = instr[13 +: RA_W];
    assign dec_imm = instr[22];

    assign dbg_data = regs[dbg_addr];

    // Condition check against the flags as they stood before this instruction.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return cf;
            4'd4:    return !cf;
            4'd5:    return n;
            4'd6:    return !n;
            4'd7:    return v;
            4'd8:    return !v;
            4'd9:    return cf && !z;
            4'd10:   return !cf || z;
            4'd11:   return n == v;
            4'd12:   return n != v;
            4'd13:   return !z && (n == v);
            4'd14:   return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    assign cond_pass = cond_eval(cond_q, flags);

    // NOTE: all state below is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            instr_ready  <= 1'b1;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= 1'b0;
            alu_n        <= '0;
            alu_i        <= '0;
            flags        <= '0;
            done         <= 1'b0;
            done_skipped <= 1'b0;
            cond_q       <= '0;
            s_q          <= 1'b0;
            rd_q         <= '0;
            result_q     <= '0;
            alu_flags_q  <= '0;
            pass_q       <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so
            // it is built from resettable flops rather than a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            done         <= 1'b0;
            done_skipped <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        cond_q      <= instr[31:28];
                        s_q         <= instr[23];
                        rd_q        <= dec_rd;
                        alu_op      <= instr[27:24];
                        alu_s       <= instr[23];
                        alu_a       <= regs[dec_rn];
                        alu_b       <= dec_imm ? '0 : regs[dec_rm];
                        alu_n       <= dec_imm ? 5'd0 : instr[12:8];
                        alu_i       <= dec_imm ? instr[15:0] : 16'd0;
                        instr_ready <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // ALU inputs have been stable for a full cycle here.
                    result_q     <= alu_result;
                    alu_flags_q  <= alu_flags;
                    pass_q       <= cond_pass;
                    done         <= 1'b1;
                    done_skipped <= !cond_pass;
                    state        <= S_WB;
                end

                S_WB: begin
                    if (pass_q) begin
                        regs[rd_q] <= result_q;
                        if (s_q) begin
                            flags <= alu_flags_q;
                        end
                    end
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
